// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 RAM arbiter.
// The font/interpreter area below PROTECT_TOP is read-only to the execute unit.
package chip8_pkg;

    localparam int ADDR_W = 12;
    localparam logic [ADDR_W-1:0] PROTECT_TOP = 12'h200;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        CAP  = 3'd2,
        ACC2 = 3'd3,
        CAP2 = 3'd4,
        ACK  = 3'd5
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_EXEC  = 2'd1,
        REQ_DRAW  = 2'd2,
        REQ_FETCH = 2'd3
    } req_id_t;

endpackage

// File: rtl/chip8_req_picker.sv
// Fixed-priority request encoder: exec beats draw, draw beats fetch.
module chip8_req_picker
    import chip8_pkg::*;
(
    input  logic    exec_req,
    input  logic    draw_req,
    input  logic    fetch_req,
    output req_id_t winner
);

    // Priority chain, highest first.
    always_comb begin
        if (exec_req) begin
            winner = REQ_EXEC;
        end else if (draw_req) begin
            winner = REQ_DRAW;
        end else if (fetch_req) begin
            winner = REQ_FETCH;
        end else begin
            winner = REQ_NONE;
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Serializes fetch/exec/draw accesses onto the single-port CHIP-8 RAM and
// assembles big-endian instructions from two consecutive byte reads.
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int                ADDR_W      = chip8_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] PROTECT_TOP = chip8_pkg::PROTECT_TOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [15:0]       fetch_instr,
    input  logic              exec_req,
    input  logic              exec_we,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [7:0]        exec_wdata,
    output logic              exec_ack,
    output logic [7:0]        exec_rdata,
    output logic              exec_err,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    output logic              draw_ack,
    output logic [7:0]        draw_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    req_id_t           id_q, id_d, pick_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [15:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              refuse_s;
    logic              ack_s;

    chip8_req_picker u_picker (
        .exec_req  (exec_req),
        .draw_req  (draw_req),
        .fetch_req (fetch_req),
        .winner    (pick_s)
    );

    assign refuse_s = (id_q == REQ_EXEC) && we_q && (addr_q < PROTECT_TOP);

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= REQ_NONE;
            addr_q  <= {ADDR_W{1'b0}};
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            data_q  <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pick_s != REQ_NONE) begin
                    state_d = ACC;
                    id_d    = pick_s;
                    err_d   = 1'b0;
                    case (pick_s)
                        REQ_EXEC: begin
                            addr_d  = exec_addr;
                            we_d    = exec_we;
                            wdata_d = exec_wdata;
                        end
                        REQ_DRAW: begin
                            addr_d  = draw_addr;
                            we_d    = 1'b0;
                            wdata_d = 8'h00;
                        end
                        default: begin
                            addr_d  = fetch_addr;
                            we_d    = 1'b0;
                            wdata_d = 8'h00;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (we_q) begin
                    err_d   = refuse_s;
                    state_d = ACK;
                end else begin
                    state_d = CAP;
                end
            end
            CAP: begin
                if (id_q == REQ_FETCH) begin
                    data_d[15:8] = mem_rdata;
                    state_d      = ACC2;
                end else begin
                    data_d[7:0] = mem_rdata;
                    state_d     = ACK;
                end
            end
            ACC2: state_d = CAP2;
            CAP2: begin
                data_d[7:0] = mem_rdata;
                state_d     = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state; rst masks strobes so an
    // in-flight write or ack dies in the reset cycle itself.
    always_comb begin
        ack_s       = (state_q == ACK) && !rst;
        fetch_ack   = ack_s && (id_q == REQ_FETCH);
        exec_ack    = ack_s && (id_q == REQ_EXEC);
        draw_ack    = ack_s && (id_q == REQ_DRAW);
        exec_err    = ack_s && (id_q == REQ_EXEC) && err_q;
        fetch_instr = data_q;
        exec_rdata  = data_q[7:0];
        draw_rdata  = data_q[7:0];
        mem_en      = !rst && (((state_q == ACC) && !refuse_s) || (state_q == ACC2));
        mem_we      = !rst && (state_q == ACC) && we_q && !refuse_s;
        mem_wdata   = wdata_q;
        busy        = (state_q != IDLE);
        if (state_q == ACC2) begin
            mem_addr = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            mem_addr = addr_q;
        end
    end

endmodule

// File: doc/chip8_mem_arbiter.md
# chip8_mem_arbiter

Sequencer and arbiter for the single-port 4 KiB CHIP-8 RAM, sitting between the `memory_access` RAM wrapper and its three requesters: instruction fetch, execute (I-register loads/stores, FX33/FX55/FX65) and sprite draw (DXYN). It serializes one transaction at a time and assembles 16-bit big-endian instructions from two byte reads. It also write-protects the interpreter/font region.

## Interface
- `ADDR_W`, 12: RAM address width; all address arithmetic is modulo 2^ADDR_W.
- `PROTECT_TOP`, 12'h200: exec writes to addresses below this are refused.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `fetch_req`  in  1: fetch request; held until `fetch_ack`.
- `fetch_addr`  in  ADDR_W: PC; stable while `fetch_req` is high.
- `fetch_ack`  out  1: one-cycle pulse; `fetch_instr` valid this cycle.
- `fetch_instr`  out  16: {mem[addr], mem[addr+1]}.
- `exec_req`  in  1: execute request; held until `exec_ack`.
- `exec_we`  in  1: 1 = write byte, 0 = read byte.
- `exec_addr`  in  ADDR_W: byte address.
- `exec_wdata`  in  8: write data.
- `exec_ack`  out  1: one-cycle completion pulse.
- `exec_rdata`  out  8: read data, valid with `exec_ack`.
- `exec_err`  out  1: high with `exec_ack` when a write was refused.
- `draw_req`  in  1: sprite byte read request.
- `draw_addr`  in  ADDR_W: byte address.
- `draw_ack`  out  1: one-cycle completion pulse.
- `draw_rdata`  out  8: sprite byte, valid with `draw_ack`.
- `mem_en`, `mem_we`  out  1: RAM enable / write enable.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_wdata`  out  8: RAM write data.
- `mem_rdata`  in  8: RAM read data; valid one cycle after `mem_en` with `mem_we`=0.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- States: IDLE, ACC, CAP, ACC2, CAP2, ACK.
- IDLE: if any req is high, latch the winner, its addr/we/wdata, and go to ACC.
- Fixed priority: exec > draw > fetch. A loser keeps its req high and is served after the winner's ACK.
- ACC drives `mem_en`=1 and `mem_addr`=latched address.
  - Exec write allowed: `mem_we`=1, then ACK.
  - Exec write refused (addr < PROTECT_TOP): `mem_en`=0, set error flag, then ACK.
  - Any read: go to CAP.
- CAP: capture `mem_rdata` into the high byte for fetch, otherwise into the data byte.
  - Fetch goes to ACC2; all other reads go to ACK.
- ACC2: read at (addr+1) mod 4096, so 12'hFFF wraps to 12'h000. Then CAP2.
- CAP2: capture the low byte, then ACK.
- ACK: pulse the winner's ack with the registered data (and `exec_err` if flagged), then IDLE.
- Requesters must drop req in the cycle after ack. A req still high then is treated as a new request.
- Reset values: state IDLE; every ack, `exec_err`, `mem_en`, `mem_we` and `busy` = 0; data registers and `mem_addr`/`mem_wdata` = 0.
- Reset mid-transaction aborts it: no ack is issued, and a write in ACC in the reset cycle is suppressed (`mem_en`/`mem_we` forced 0).

## Timing
- Request first visible at edge E0 in IDLE. Ack cycle, counted after E0:
  - Allowed write: cycle 2.
  - Refused write: cycle 2.
  - Byte read: cycle 3.
  - Fetch: cycle 5.
- Memory outputs are decoded from registered state only; no combinational path from any req to `mem_*`.
- Back-to-back: the earliest next grant is sampled in IDLE one cycle after ACK.

## Structure
- `chip8_pkg` holds:
  - `ADDR_W`, `PROTECT_TOP`.
  - State enum `arb_state_t`.
  - Requester enum `req_id_t` {REQ_NONE, REQ_EXEC, REQ_DRAW, REQ_FETCH}.
- Sub-module `chip8_req_picker`: combinational fixed-priority encoder, three reqs → `req_id_t`.
- The top level holds the FSM, the latched request and the data registers.

## Test plan
- Fetch at 12'h200 with mem[200]=8'h6A, mem[201]=8'h05 → `fetch_ack` in cycle 5, `fetch_instr`=16'h6A05; exactly two `mem_en` cycles, at addresses 200 and 201.
- Fetch at 12'hFFF with mem[FFF]=8'h12, mem[000]=8'h34 → `fetch_instr`=16'h1234 (wrap).
- Exec, draw and fetch req all asserted at the same edge → acks in order exec, draw, fetch; no overlap; each loser's req held throughout.
- Exec write 8'hAB to 12'h300 → `exec_ack` in cycle 2, `exec_err`=0; a following exec read of 300 returns 8'hAB.
- Exec write to 12'h050 → `exec_ack` with `exec_err`=1; `mem_we` never asserted; mem[050] unchanged.
- `rst` asserted during CAP of a fetch → no `fetch_ack`, all outputs 0 next cycle; a fresh fetch after reset completes normally.
